// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream boot loader that fills instruction memory and holds the CPU in reset
// Optional feature macro: BOOT_CHECKSUM_EN (XOR checksum byte after the image data).
// Stream: LEN_HI, LEN_LO (word count N, big-endian), then 4*N data bytes, MSB of each word first.

module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Length limit widened by one bit so that N up to 65535 compares cleanly.
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_FIN    = 3'd3,
    S_DONE   = 3'd4,
`ifdef BOOT_CHECKSUM_EN
    S_CHK    = 3'd6,
`endif
    S_ERR    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_q, word_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  logic                accept;
  logic [15:0]         len_full;
  logic [31:0]         word_next;
  logic                last_word;

  assign accept    = in_valid && in_ready;
  assign len_full  = {len_q[15:8], in_data};
  assign word_next = {word_q[23:0], in_data};
  assign last_word = ((word_cnt_q + 16'd1) == len_q);

  // Byte acceptance is purely a function of the current state.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      S_CHK:                      in_ready = 1'b1;
`endif
      default:                    in_ready = 1'b0;
    endcase
  end

  // Next-state and datapath updates; the write strobe is a registered one-shot.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef BOOT_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d      = len_full;
          word_cnt_d = 16'd0;
          byte_idx_d = 2'd0;
          word_d     = 32'd0;
`ifdef BOOT_CHECKSUM_EN
          xor_d      = 8'h00;
`endif
          if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_W)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d     = word_next;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          xor_d      = xor_q ^ in_data;
`endif
          if (byte_idx_q == 2'd3) begin
            // Word complete: strobe it out next cycle while input keeps flowing.
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = word_next;
            word_cnt_d = word_cnt_q + 16'd1;
            if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_FIN;
`endif
            end
          end
        end
      end

      // Final write pulse is on the bus during this cycle.
      S_FIN: begin
        state_d = S_DONE;
      end

`ifdef BOOT_CHECKSUM_EN
      // The final write pulse overlaps the first cycle here; the checksum byte may arrive at once.
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
      end
`endif

      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_LEN_HI;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LEN_HI;
      len_q      <= 16'd0;
      word_cnt_q <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      xor_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign cpu_hold   = !done;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench for imem_boot_loader

module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_boot_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;
  logic [7:0]  stream[$];
  wr_t         exp_q[$];
  logic [31:0] mem_model[256];
  logic [31:0] mem_dut[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory stand-in plus write-sequence scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (imem_we === 1'b1) begin
      pulse_cnt++;
      mem_dut[imem_addr] = imem_wdata;
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      check("we_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("we_addr", {24'd0, imem_addr}, {24'd0, w.a});
        check("we_data", imem_wdata, w.d);
      end
    end
`ifndef BOOT_CHECKSUM_EN
    if (done === 1'b1 && prev_done === 1'b0) check("done_after_last_we", {31'd0, prev_we}, 32'd1);
`endif
    prev_we   = (imem_we === 1'b1);
    prev_done = (done === 1'b1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pulse_cnt = 0;
  endtask

  // Image bytes: length header, data MSB-first, optional XOR byte (flip corrupts it).
  task automatic build(input logic [31:0] ws[$], input logic [7:0] flip);
    logic [15:0] n;
    logic [7:0]  x;
    logic [7:0]  b;
    n = 16'(ws.size());
    x = 8'h00;
    stream.delete();
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    foreach (ws[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b = ws[i][8*k +: 8];
        stream.push_back(b);
        x = x ^ b;
      end
    end
    x = x ^ flip;
`ifdef BOOT_CHECKSUM_EN
    stream.push_back(x);
`endif
  endtask

  task automatic expect_words(input logic [31:0] ws[$]);
    wr_t w;
    foreach (ws[i]) begin
      w.a = 8'(i);
      w.d = ws[i];
      exp_q.push_back(w);
      mem_model[i] = ws[i];
    end
  endtask

  // Offer each byte, with random idle gaps of gap_pct percent; returns one ns after the last acceptance edge.
  task automatic send(input int gap_pct);
    int t;
    foreach (stream[i]) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      if (in_ready !== 1'b1) begin
        check("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  initial begin
    logic [31:0] ws[$];
    int n;

    for (int i = 0; i < 256; i++) begin
      mem_model[i] = 32'd0;
      mem_dut[i]   = 32'd0;
    end

    // Reset values
    do_reset();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);

    // Two-word image, back-to-back
    ws = '{32'h20080005, 32'h21090007};
    build(ws, 8'h00);
    expect_words(ws);
    send(0);
`ifndef BOOT_CHECKSUM_EN
    check("t1_final_we", {31'd0, imem_we}, 32'd1);
    check("t1_done_not_yet", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
`endif
    wait_end();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("t1_in_ready", {31'd0, in_ready}, 32'd0);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_pulses", 32'(pulse_cnt), 32'd2);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      check("t1_post_done_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("t1_pulses_after_extra", 32'(pulse_cnt), 32'd2);
    check("t1_done_sticky", {31'd0, done}, 32'd1);

    // Zero-length header
    do_reset();
    stream = '{8'h00, 8'h00};
    send(0);
    check("t2_error", {31'd0, error}, 32'd1);
    check("t2_in_ready", {31'd0, in_ready}, 32'd0);
    check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t2_done", {31'd0, done}, 32'd0);
    check("t2_pulses", 32'(pulse_cnt), 32'd0);

    // Length one past the limit
    do_reset();
    stream = '{8'h01, 8'h01};
    send(30);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t3_pulses", 32'(pulse_cnt), 32'd0);

    // Largest legal image
    do_reset();
    ws.delete();
    for (int i = 0; i < 256; i++) ws.push_back($urandom);
    build(ws, 8'h00);
    expect_words(ws);
    send(0);
    wait_end();
    check("t3b_done", {31'd0, done}, 32'd1);
    check("t3b_pulses", 32'(pulse_cnt), 32'd256);

    // Three words with a randomly toggling in_valid
    do_reset();
    ws = '{32'h11111111, 32'h22222222, 32'h33333333};
    build(ws, 8'h00);
    expect_words(ws);
    send(50);
    wait_end();
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_pulses", 32'(pulse_cnt), 32'd3);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-load, then a fresh one-word image
    do_reset();
    ws = '{32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
    build(ws, 8'h00);
    while (stream.size() > 8) void'(stream.pop_back());
    ws = '{32'hCAFEF00D};
    expect_words(ws);
    send(0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_partial_pulses", 32'(pulse_cnt), 32'd1);
    check("t5_partial_done", {31'd0, done}, 32'd0);
    check("t5_partial_ready", {31'd0, in_ready}, 32'd1);
    do_reset();
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    ws = '{32'hDEADBEEF};
    build(ws, 8'h00);
    expect_words(ws);
    send(0);
    wait_end();
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_pulses", 32'(pulse_cnt), 32'd1);
    check("t5_word0", mem_dut[0], 32'hDEADBEEF);

    // Random images
    for (int r = 0; r < 10; r++) begin
      do_reset();
      n = $urandom_range(1, 8);
      ws.delete();
      for (int i = 0; i < n; i++) ws.push_back($urandom);
      build(ws, 8'h00);
      expect_words(ws);
      send($urandom_range(0, 60));
      wait_end();
      check("rnd_done", {31'd0, done}, 32'd1);
      check("rnd_error", {31'd0, error}, 32'd0);
      check("rnd_pulses", 32'(pulse_cnt), 32'(n));
      check("rnd_drained", 32'(exp_q.size()), 32'd0);
    end

`ifdef BOOT_CHECKSUM_EN
    // Checksum match and mismatch
    do_reset();
    ws = '{32'h01020304};
    build(ws, 8'h00);
    check("ck_byte", {24'd0, stream[stream.size()-1]}, 32'h04);
    expect_words(ws);
    send(0);
    check("ck_ok_done", {31'd0, done}, 32'd1);
    check("ck_ok_error", {31'd0, error}, 32'd0);
    do_reset();
    mem_dut[0] = 32'd0;
    build(ws, 8'h01);
    expect_words(ws);
    send(0);
    repeat (2) @(posedge clk);
    #1;
    check("ck_bad_error", {31'd0, error}, 32'd1);
    check("ck_bad_done", {31'd0, done}, 32'd0);
    check("ck_bad_hold", {31'd0, cpu_hold}, 32'd1);
    check("ck_bad_word0", mem_dut[0], 32'h01020304);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 256; i++) check("mem_image", mem_dut[i], mem_model[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
